// File: rtl/neuron_grid_pkg.sv
// Shared constants and state encoding for the serial neuron grid.
// Used by the accumulator and the saturation helper.
package neuron_grid_pkg;

  localparam int ACC_OUT_W = 18;
  localparam int MSB_W     = 6;
  localparam int LSB_W     = 12;
  localparam int ACC_MAX   = 131071;
  localparam int ACC_MIN   = -131072;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/neuron_ser_acc_if.sv
// Bit-serial input and result handshake bundle
// between a neuron source and the accumulator.
interface neuron_ser_acc_if #(
  parameter int W_WIDTH = 8
);

  logic               start;
  logic               in_valid;
  logic               in_ready;
  logic               x_bit;
  logic [W_WIDTH-1:0] w;
  logic               dout_valid;
  logic               dout_ready;
  logic [5:0]         dout_msb;
  logic [11:0]        dout_lsb;
  logic               busy;

  modport master (
    output start, in_valid, x_bit, w,
    output dout_ready,
    input  in_ready, dout_valid,
    input  dout_msb, dout_lsb, busy
  );

  modport slave (
    input  start, in_valid, x_bit, w,
    input  dout_ready,
    output in_ready, dout_valid,
    output dout_msb, dout_lsb, busy
  );

endinterface

// File: rtl/neuron_sat18.sv
// Combinational clamp of a wide signed sum
// into the 18-bit signed grid range.
module neuron_sat18
  import neuron_grid_pkg::*;
#(
  parameter int IN_W = 24
) (
  input  logic signed [IN_W-1:0]      i_acc,
  output logic        [ACC_OUT_W-1:0] o_sat
);

  localparam logic signed [IN_W-1:0] MAXV =
    IN_W'(ACC_MAX);
  localparam logic signed [IN_W-1:0] MINV =
    IN_W'(ACC_MIN);

  always_comb begin
    o_sat = i_acc[ACC_OUT_W-1:0];
    if (i_acc > MAXV)
      o_sat = MAXV[ACC_OUT_W-1:0];
    else if (i_acc < MINV)
      o_sat = MINV[ACC_OUT_W-1:0];
  end

endmodule

// File: rtl/neuron_ser_acc.sv
// Bit-serial shift-add neuron accumulator producing
// the saturated 18-bit pre-activation value.
module neuron_ser_acc
  import neuron_grid_pkg::*;
#(
  parameter int W_WIDTH   = 8,
  parameter int X_BITS    = 8,
  parameter int N_INPUTS  = 16,
  parameter int ACC_INT_W = 24
) (
  input logic            clk,
  input logic            rst,
  neuron_ser_acc_if.slave bus
);

  localparam int BC_W =
    (X_BITS > 1) ? $clog2(X_BITS) : 1;
  localparam int IC_W =
    (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  state_e                 r_state;
  logic signed [ACC_INT_W-1:0] r_acc;
  logic [BC_W-1:0]        r_bit_cnt;
  logic [IC_W-1:0]        r_in_cnt;
  logic                   r_in_ready;
  logic                   r_dout_valid;
  logic [MSB_W-1:0]       r_dout_msb;
  logic [LSB_W-1:0]       r_dout_lsb;
  logic                   r_busy;

  logic signed [ACC_INT_W-1:0] w_wext;
  logic signed [ACC_INT_W-1:0] w_addend;
  logic signed [ACC_INT_W-1:0] w_acc_nxt;
  logic [ACC_OUT_W-1:0]   w_sat;
  logic                   w_accept;
  logic                   w_last_bit;
  logic                   w_last_in;

  assign w_wext =
    ACC_INT_W'(signed'(bus.w));
  assign w_addend = bus.x_bit
    ? (w_wext <<< r_bit_cnt)
    : '0;
  assign w_acc_nxt = r_acc + w_addend;
  assign w_accept =
    bus.in_valid & r_in_ready;
  assign w_last_bit =
    (r_bit_cnt == BC_W'(X_BITS - 1));
  assign w_last_in =
    (r_in_cnt == IC_W'(N_INPUTS - 1));

  // clamp sees the sum including the final bit
  neuron_sat18 #(
    .IN_W(ACC_INT_W)
  ) u_sat (
    .i_acc(w_acc_nxt),
    .o_sat(w_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_bit_cnt    <= '0;
      r_in_cnt     <= '0;
      r_in_ready   <= 1'b0;
      r_dout_valid <= 1'b0;
      r_dout_msb   <= '0;
      r_dout_lsb   <= '0;
      r_busy       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_acc      <= '0;
            r_bit_cnt  <= '0;
            r_in_cnt   <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_acc <= w_acc_nxt;
            if (w_last_bit) begin
              r_bit_cnt <= '0;
              r_in_cnt  <= r_in_cnt + 1'b1;
              if (w_last_in) begin
                r_in_ready   <= 1'b0;
                r_dout_valid <= 1'b1;
                r_dout_msb   <=
                  w_sat[ACC_OUT_W-1:LSB_W];
                r_dout_lsb   <=
                  w_sat[LSB_W-1:0];
                r_state      <= S_DONE;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (bus.dout_ready) begin
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.dout_valid = r_dout_valid;
  assign bus.dout_msb   = r_dout_msb;
  assign bus.dout_lsb   = r_dout_lsb;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_neuron_ser_acc.sv
// Table-driven bench for neuron_ser_acc with a
// result scoreboard and flow-control/abort sequences.
module tb_neuron_ser_acc;

  localparam int NI = 16;
  localparam int XB = 8;

  typedef struct {
    logic signed [7:0] w [NI];
    logic [7:0]        x [NI];
    logic [17:0]       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  neuron_ser_acc_if #(.W_WIDTH(8)) bus();

  neuron_ser_acc #(
    .W_WIDTH(8),
    .X_BITS(XB),
    .N_INPUTS(NI),
    .ACC_INT_W(24)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  logic [17:0] sbq[$];
  vec_t tbl[5];

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
        nm, act, exp);
    end
  endtask

  function automatic logic [17:0] model(
    input vec_t v
  );
    int s;
    s = 0;
    for (int i = 0; i < NI; i++)
      s += int'(v.w[i]) * int'(v.x[i]);
    if (s > 131071) s = 131071;
    if (s < -131072) s = -131072;
    return s[17:0];
  endfunction

  task automatic run_eval(
    input int  idx,
    input bit  gaps,
    input bit  hold,
    input bit  chk_lat
  );
    vec_t v;
    int cyc;
    bit seen;
    logic [17:0] exp;
    v = tbl[idx];
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.in_valid = 1'b0;
    sbq.push_back(v.exp);
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 2;
    chk("in_ready_accum", 32'(bus.in_ready), 1);
    chk("busy_accum", 32'(bus.busy), 1);
    for (int i = 0; i < NI; i++) begin
      for (int b = 0; b < XB; b++) begin
        if (gaps) begin
          while ($urandom_range(1) == 1) begin
            bus.in_valid = 1'b0;
            bus.x_bit = 1'($urandom_range(1));
            bus.start = 1'($urandom_range(1));
            @(posedge clk); #1;
            cyc++;
          end
        end
        bus.in_valid = 1'b1;
        bus.x_bit = v.x[i][b];
        bus.w = v.w[i];
        bus.start = gaps ?
          1'($urandom_range(1)) : 1'b0;
        if (i == NI - 1 && b == XB - 1)
          chk("no_early_valid",
            32'(bus.dout_valid), 0);
        @(posedge clk); #1;
        cyc++;
      end
    end
    bus.in_valid = 1'b0;
    bus.start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.dout_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!seen) begin
      chk("dout_valid_timeout", 0, 1);
      void'(sbq.pop_front());
      return;
    end
    if (chk_lat) chk("latency", cyc, 130);
    exp = sbq.pop_front();
    chk("result",
      {bus.dout_msb, bus.dout_lsb}, exp);
    if (hold) begin
      bus.dout_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
        bus.start = 1'b1;
        @(posedge clk); #1;
        chk("hold_stable",
          {bus.dout_msb, bus.dout_lsb}, exp);
        chk("hold_valid",
          32'(bus.dout_valid), 1);
      end
    end
    bus.dout_ready = 1'b1;
    @(posedge clk); #1;
    bus.dout_ready = 1'b0;
    bus.start = 1'b0;
    chk("valid_drop", 32'(bus.dout_valid), 0);
    chk("busy_idle", 32'(bus.busy), 0);
    chk("out_kept",
      {bus.dout_msb, bus.dout_lsb}, exp);
  endtask

  task automatic abort_run(input int idx);
    vec_t v;
    int n;
    v = tbl[idx];
    n = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < NI && n < 40; i++) begin
      for (int b = 0; b < XB && n < 40; b++) begin
        bus.in_valid = 1'b1;
        bus.x_bit = v.x[i][b];
        bus.w = v.w[i];
        @(posedge clk); #1;
        n++;
      end
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_valid", 32'(bus.dout_valid), 0);
    chk("abort_ready", 32'(bus.in_ready), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_out",
      {bus.dout_msb, bus.dout_lsb}, 0);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      tbl[0].w[i] = 8'($urandom_range(255));
      tbl[0].x[i] = 8'd0;
      tbl[1].w[i] = 8'($urandom_range(255));
      tbl[1].x[i] = 8'd0;
      tbl[2].w[i] = 8'sd127;
      tbl[2].x[i] = 8'd255;
      tbl[3].w[i] = -8'sd128;
      tbl[3].x[i] = 8'd255;
      tbl[4].w[i] = 8'($urandom_range(255));
      tbl[4].x[i] = 8'($urandom_range(63));
    end
    tbl[0].w[0] = 8'sd5;
    tbl[0].x[0] = 8'd3;
    tbl[0].exp  = 18'h0000F;
    tbl[1].w[0] = -8'sd1;
    tbl[1].x[0] = 8'd1;
    tbl[1].exp  = 18'h3FFFF;
    tbl[2].exp  = 18'h1FFFF;
    tbl[3].exp  = 18'h20000;
    tbl[4].exp  = model(tbl[4]);

    rst = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.x_bit = 1'b0;
    bus.w = '0;
    bus.dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_valid", 32'(bus.dout_valid), 0);
    chk("rst_msb", 32'(bus.dout_msb), 0);
    chk("rst_lsb", 32'(bus.dout_lsb), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    rst = 1'b0;

    for (int t = 0; t < 4; t++)
      run_eval(t, 1'b0, 1'b0, t == 0);
    run_eval(4, 1'b0, 1'b0, 1'b0);
    run_eval(4, 1'b1, 1'b1, 1'b0);
    run_eval(2, 1'b1, 1'b1, 1'b0);
    abort_run(2);
    run_eval(0, 1'b0, 1'b1, 1'b1);

    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d",
      total, bad);
    $finish;
  end

endmodule
